// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD sequencer and engine: state encoding, slot geometry
// and default widths.
package sgd_pkg;

    localparam int unsigned ADDR_WIDTH_DEF   = 12;
    localparam int unsigned MAX_FEATURES_DEF = 15;
    localparam int unsigned LENGTH_DEF       = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StCapt    = 3'd2,
        StPresent = 3'd3,
        StDrain   = 3'd4,
        StDone    = 3'd5
    } sched_state_e;

    // Slot 0 (y / bias) sits in the most significant bits of the word.
    function automatic int unsigned slot_msb(input int unsigned data_width,
                                             input int unsigned length,
                                             input int unsigned j);
        return data_width - 1 - length * j;
    endfunction

endpackage

// File: rtl/sgd_feat_mask.sv
// Zeroes every feature slot above the active feature count; slot 0 is always kept.
module sgd_feat_mask
    import sgd_pkg::*;
#(
    parameter int unsigned LENGTH       = LENGTH_DEF,
    parameter int unsigned MAX_FEATURES = MAX_FEATURES_DEF,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic [3:0]            feat,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    int unsigned f_eff;

    assign f_eff = (32'(feat) > MAX_FEATURES) ? MAX_FEATURES : 32'(feat);

    always_comb begin
        data_out = '0;
        for (int unsigned j = 0; j <= MAX_FEATURES; j++) begin
            if (j <= f_eff) begin
                data_out[slot_msb(DATA_WIDTH, LENGTH, j) -: LENGTH] =
                    data_in[slot_msb(DATA_WIDTH, LENGTH, j) -: LENGTH];
            end
        end
    end

endmodule

// File: rtl/sgd_sched.sv
// Dataset sequencer for the SGD engine: fetches the initial weights, streams points
// 1..N for E epochs over valid/ready, then captures the engine's final weights.
module sgd_sched
    import sgd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned MAX_FEATURES = MAX_FEATURES_DEF,
    parameter int unsigned LENGTH       = LENGTH_DEF,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            cfg_feat,
    input  logic [ADDR_WIDTH-1:0] cfg_data_points,
    input  logic [7:0]            cfg_epoch,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  pt_valid,
    output logic                  pt_init,
    output logic                  pt_last,
    output logic [DATA_WIDTH-1:0] pt_data,
    input  logic                  pt_ready,
    input  logic                  wt_valid,
    input  logic [DATA_WIDTH-1:0] wt_data,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [7:0]            epoch_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    sched_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [7:0]            e_q;
    logic [3:0]            f_q;
    logic                  init_q;
    logic [7:0]            epoch_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] w_q;
    logic [DATA_WIDTH-1:0] masked;
    logic [7:0]            epoch_next;

    assign epoch_next = epoch_q + 8'd1;

    sgd_feat_mask #(
        .LENGTH       (LENGTH),
        .MAX_FEATURES (MAX_FEATURES),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_feat_mask (
        .feat     (f_q),
        .data_in  (ram_rdata),
        .data_out (masked)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            n_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            init_q  <= 1'b0;
            epoch_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            w_q     <= '0;
        end else if (abort) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        n_q     <= cfg_data_points;
                        e_q     <= cfg_epoch;
                        f_q     <= cfg_feat;
                        epoch_q <= '0;
                        err_q   <= 1'b0;
                        if (cfg_data_points == '0 || cfg_epoch == '0) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            addr_q  <= '0;
                            init_q  <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: state_q <= StCapt;
                StCapt: begin
                    data_q  <= masked;
                    state_q <= StPresent;
                end
                StPresent: begin
                    if (pt_ready) begin
                        if (init_q) begin
                            init_q  <= 1'b0;
                            addr_q  <= ADDR_WIDTH'(1);
                            state_q <= StFetch;
                        end else if (addr_q < n_q) begin
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            state_q <= StFetch;
                        end else begin
                            epoch_q <= epoch_next;
                            if (epoch_next == e_q) begin
                                state_q <= StDrain;
                            end else begin
                                addr_q  <= ADDR_WIDTH'(1);
                                state_q <= StFetch;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (wt_valid) begin
                        w_q     <= wt_data;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake strobes are gated by abort so they fall in the abort cycle itself.
    assign ram_en    = (state_q == StFetch) && !abort;
    assign ram_addr  = addr_q;
    assign pt_valid  = (state_q == StPresent) && !abort;
    assign pt_init   = (state_q == StPresent) && init_q;
    assign pt_last   = (state_q == StPresent) && !init_q && (addr_q == n_q);
    assign pt_data   = data_q;
    assign w_out     = w_q;
    assign epoch_cnt = epoch_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign cfg_err   = err_q;

endmodule
